point_writer: RTL and testbench



---
 rtl/point_writer_pkg.sv | 41 ++++
 rtl/point_writer_if.sv | 17 +
 rtl/point_writer_zbt_write_delay.sv | 34 +++
 rtl/point_writer.sv | 140 ++++++++++++++
 tb/tb_point_writer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/point_writer_pkg.sv
// Shared definitions for the point list stored in ZBT0: word field layout,
// the terminator word, the writer state encoding and the packing helper.
package point_writer_pkg;

    localparam int COORD_W  = 10;
    localparam int WORD_W   = 36;

    // Field positions inside one 36-bit point word (renderer reads the same layout)
    localparam int Z_LSB    = 0;
    localparam int Z_MSB    = 9;
    localparam int Y_LSB    = 10;
    localparam int Y_MSB    = 19;
    localparam int X_LSB    = 20;
    localparam int X_MSB    = 29;
    localparam int TERM_BIT = 35;

    // End-of-list marker: only the terminator flag set
    localparam logic [WORD_W-1:0] TERM_WORD = 36'h8_0000_0000;

    // FLUSH is a one-cycle gap used when a point is written on the scan_end
    // cycle, so the point write and the terminator write never collide.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_FLUSH     = 3'd2,
        ST_TERMINATE = 3'd3,
        ST_DONE      = 3'd4
    } pw_state_e;

    function automatic logic [WORD_W-1:0] pack_point(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y,
                                                     input logic [COORD_W-1:0] z);
        logic [WORD_W-1:0] w;
        w = '0;
        w[X_MSB:X_LSB] = x;
        w[Y_MSB:Y_LSB] = y;
        w[Z_MSB:Z_LSB] = z;
        return w;
    endfunction

endpackage

// File: rtl/point_writer_if.sv
// Point stream from the scanner into the writer.
// Handshake: a point transfers at a rising clk edge where in_valid && in_ready;
// the source holds in_x/in_y/in_z stable while in_valid is high and unaccepted,
// and in_ready depends only on registered writer state.
interface point_writer_if;
    import point_writer_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;
    logic [COORD_W-1:0] in_z;

    modport master (output in_valid, output in_x, output in_y, output in_z, input in_ready);
    modport slave  (input in_valid, input in_x, input in_y, input in_z, output in_ready);

endinterface

// File: rtl/point_writer_zbt_write_delay.sv
// Two-stage data delay for pipelined ZBT writes: data presented with the
// we/addr cycle comes out two cycles later. Synchronous active-low clear.
module zbt_write_delay
    import point_writer_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] s1_q, s1_d;
    logic [WORD_W-1:0] s2_q, s2_d;

    // Next-stage values: a plain shift
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Delay registers, cleared together
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/point_writer.sv
// Writes detected scan points into ZBT0 as packed words at consecutive
// addresses from 0, then appends a terminator. Points with z==0 are dropped;
// the last word is kept free so the terminator always fits.
module point_writer
    import point_writer_pkg::*;
#(
    parameter int ADDR_W     = 19,
    parameter int MAX_POINTS = 524288
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scan_start,
    input  logic              scan_end,
    point_writer_if.slave     pt,
    output logic [ADDR_W-1:0] zbt0_write_addr,
    output logic              zbt0_we,
    output logic [WORD_W-1:0] zbt0_write_data,
    output logic [ADDR_W-1:0] point_count,
    output logic              overflow,
    output logic              done,
    output pw_state_e         state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_POINTS - 1);

    pw_state_e         state_q, state_d;
    // Write pointer; it always equals the number of points written this scan,
    // so it doubles as point_count.
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic              accept;
    logic              point_wr;

    // Next-state, pointer, write-issue and registered-output logic
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ovf_d    = ovf_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        word_d   = '0;
        point_wr = 1'b0;
        accept   = pt.in_valid && in_ready_q;

        if (scan_start) begin
            // A new scan always wins, including over scan_end and any point
            // offered in the same cycle.
            state_d = ST_CAPTURE;
            ptr_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (accept && (pt.in_z != '0)) begin
                        if (ptr_q != LAST_ADDR) begin
                            point_wr = 1'b1;
                            we_d     = 1'b1;
                            addr_d   = ptr_q;
                            word_d   = pack_point(pt.in_x, pt.in_y, pt.in_z);
                            ptr_d    = ptr_q + ADDR_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (scan_end) begin
                        if (point_wr) begin
                            // The point occupies the next write slot
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_TERMINATE;
                            we_d    = 1'b1;
                            addr_d  = ptr_q;
                            word_d  = TERM_WORD;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_TERMINATE;
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    word_d  = TERM_WORD;
                end
                ST_TERMINATE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        in_ready_d = (state_d == ST_CAPTURE);
        done_d     = (state_d == ST_TERMINATE) || (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            ovf_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            word_q     <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ovf_q      <= ovf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
        end
    end

    // word_q lines up with the we/addr cycle; two more stages give the ZBT data timing
    zbt_write_delay u_data_delay (
        .clk   (clk),
        .clr_n (reset_n),
        .d     (word_q),
        .q     (zbt0_write_data)
    );

    assign pt.in_ready      = in_ready_q;
    assign zbt0_we          = we_q;
    assign zbt0_write_addr  = addr_q;
    assign point_count      = ptr_q;
    assign overflow         = ovf_q;
    assign done             = done_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_point_writer.sv
// Directed bench for point_writer with a write scoreboard.
module tb_point_writer;
    import point_writer_pkg::*;

    localparam int ADDR_W = 19;
    localparam int MAXP   = 8;
    localparam int EW     = ADDR_W + 36;
    localparam logic [35:0] TERM = 36'h8_0000_0000;

    logic              clk;
    logic              reset_n;
    logic              scan_start;
    logic              scan_end;
    logic [ADDR_W-1:0] zbt0_write_addr;
    logic              zbt0_we;
    logic [35:0]       zbt0_write_data;
    logic [ADDR_W-1:0] point_count;
    logic              overflow;
    logic              done;
    pw_state_e         state_dbg;

    point_writer_if pt ();

    point_writer #(.ADDR_W(ADDR_W), .MAX_POINTS(MAXP)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .scan_start      (scan_start),
        .scan_end        (scan_end),
        .pt              (pt),
        .zbt0_write_addr (zbt0_write_addr),
        .zbt0_we         (zbt0_we),
        .zbt0_write_data (zbt0_write_data),
        .point_count     (point_count),
        .overflow        (overflow),
        .done            (done),
        .state_dbg       (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [35:0] exp_word(input logic [9:0] x, input logic [9:0] y,
                                            input logic [9:0] z);
        return {6'b0, x, y, z};
    endfunction

    function automatic logic [EW-1:0] entry(input int a, input logic [35:0] d);
        return {ADDR_W'(a), d};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic              we_p1 = 1'b0, we_p2 = 1'b0;
    logic [ADDR_W-1:0] addr_p1 = '0, addr_p2 = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (we_p2) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write: unexpected write addr %0h data %0h", addr_p2, zbt0_write_data);
                end else begin
                    check("write", {9'b0, addr_p2, zbt0_write_data}, {9'b0, exp_q.pop_front()});
                end
            end else if (zbt0_write_data !== 36'h0) begin
                check("idle_data", {28'b0, zbt0_write_data}, 64'h0);
            end
            we_p2   = we_p1;
            addr_p2 = addr_p1;
            we_p1   = zbt0_we;
            addr_p1 = zbt0_write_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] z, input logic ss, input logic se);
        pt.in_valid = v;
        pt.in_x     = x;
        pt.in_y     = y;
        pt.in_z     = z;
        scan_start  = ss;
        scan_end    = se;
        @(posedge clk); #1;
        pt.in_valid = 1'b0;
        scan_start  = 1'b0;
        scan_end    = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", {63'b0, done}, 64'h1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n     = 1'b0;
        scan_start  = 1'b0;
        scan_end    = 1'b0;
        pt.in_valid = 1'b0;
        pt.in_x     = '0;
        pt.in_y     = '0;
        pt.in_z     = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_we", {63'b0, zbt0_we}, 64'h0);
        check("rst_addr", {45'b0, zbt0_write_addr}, 64'h0);
        check("rst_data", {28'b0, zbt0_write_data}, 64'h0);
        check("rst_count", {45'b0, point_count}, 64'h0);
        check("rst_ovf", {63'b0, overflow}, 64'h0);
        check("rst_done", {63'b0, done}, 64'h0);
        check("rst_ready", {63'b0, pt.in_ready}, 64'h0);
        check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
        reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(1);

        // Basic scan: three points back to back, then terminator
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
        check("cap_ready", {63'b0, pt.in_ready}, 64'h1);
        exp_q.push_back(entry(0, 36'h0_0010_0803));
        exp_q.push_back(entry(1, 36'h0_0040_1406));
        exp_q.push_back(entry(2, 36'h0_0070_2009));
        exp_q.push_back(entry(3, TERM));
        drive(1'b1, 10'd1, 10'd2, 10'd3, 1'b0, 1'b0);
        check("count_n1", {45'b0, point_count}, 64'd1);
        drive(1'b1, 10'd4, 10'd5, 10'd6, 1'b0, 1'b0);
        drive(1'b1, 10'd7, 10'd8, 10'd9, 1'b0, 1'b0);
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        wait_done();
        check("basic_count", {45'b0, point_count}, 64'd3);
        check("basic_ready", {63'b0, pt.in_ready}, 64'h0);
        idle(4);

        // Mixed z: the z==0 point is dropped
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
        check("restart_done", {63'b0, done}, 64'h0);
        exp_q.push_back(entry(0, 36'h0_0140_5005));
        exp_q.push_back(entry(1, TERM));
        drive(1'b1, 10'd10, 10'd10, 10'd0, 1'b0, 1'b0);
        drive(1'b1, 10'd20, 10'd20, 10'd5, 1'b0, 1'b0);
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        wait_done();
        check("mixed_count", {45'b0, point_count}, 64'd1);
        idle(4);

        // Overflow: 10 points into an 8-word memory
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i < 7) exp_q.push_back(entry(i, exp_word(10'(i + 1), 10'(i + 2), 10'(i + 3))));
            drive(1'b1, 10'(i + 1), 10'(i + 2), 10'(i + 3), 1'b0, 1'b0);
            if (i == 6) check("ovf_before", {63'b0, overflow}, 64'h0);
        end
        exp_q.push_back(entry(7, TERM));
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        wait_done();
        check("ovf_flag", {63'b0, overflow}, 64'h1);
        check("ovf_count", {45'b0, point_count}, 64'd7);
        idle(4);

        // Point accepted in the scan_end cycle
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
        check("ovf_cleared", {63'b0, overflow}, 64'h0);
        exp_q.push_back(entry(0, 36'h0_0010_0401));
        exp_q.push_back(entry(1, 36'h0_0020_0802));
        exp_q.push_back(entry(2, TERM));
        drive(1'b1, 10'd1, 10'd1, 10'd1, 1'b0, 1'b0);
        drive(1'b1, 10'd2, 10'd2, 10'd2, 1'b0, 1'b1);
        check("end_ready_low", {63'b0, pt.in_ready}, 64'h0);
        wait_done();
        check("end_count", {45'b0, point_count}, 64'd2);
        idle(4);

        // scan_start in the middle of a capture, after overflowing
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i < 7) exp_q.push_back(entry(i, exp_word(10'(i), 10'(i), 10'd1)));
            drive(1'b1, 10'(i), 10'(i), 10'd1, 1'b0, 1'b0);
        end
        check("mid_ovf_set", {63'b0, overflow}, 64'h1);
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
        exp_q.push_back(entry(0, 36'h0_0030_0C03));
        drive(1'b1, 10'd3, 10'd3, 10'd3, 1'b0, 1'b0);
        check("mid_count", {45'b0, point_count}, 64'd1);
        check("mid_ovf_clr", {63'b0, overflow}, 64'h0);
        exp_q.push_back(entry(1, TERM));
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        wait_done();
        idle(4);

        // Reset with a write in flight: its data slot completes as zero
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
        exp_q.push_back(entry(0, 36'h0));
        pt.in_valid = 1'b1;
        pt.in_x = 10'd5;
        pt.in_y = 10'd6;
        pt.in_z = 10'd7;
        @(posedge clk); #1;
        check("flight_we", {63'b0, zbt0_we}, 64'h1);
        pt.in_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("mrst_we", {63'b0, zbt0_we}, 64'h0);
        check("mrst_count", {45'b0, point_count}, 64'h0);
        check("mrst_ready", {63'b0, pt.in_ready}, 64'h0);
        check("mrst_state", 64'(state_dbg), 64'(ST_IDLE));
        // Idle: points and scan_end must not cause writes
        drive(1'b1, 10'd1, 10'd1, 10'd1, 1'b0, 1'b0);
        drive(1'b1, 10'd2, 10'd2, 10'd2, 1'b0, 1'b1);
        drive(1'b1, 10'd3, 10'd3, 10'd3, 1'b0, 1'b0);
        check("idle_state", 64'(state_dbg), 64'(ST_IDLE));
        check("idle_done", {63'b0, done}, 64'h0);
        idle(5);

        // Final report
        check("drain", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
